fill_ones_sm: RTL and testbench
===============================

Name: fill_ones_sm

Overview:
- Inverse of the serial ones-counter: takes a bit count N and builds a `word_size`-bit word containing exactly N ones, right-justified (LSBs).
- Builds the word serially, shifting in one '1' per clock.
- Uses the same start/busy/done handshake as the ones-counter, so the two blocks can be chained for round-trip checking.
- Sits beside the counter in the Chapter 6 datapath/controller examples.

Parameters:
- counter_size, 3: width of count input.
- word_size, 4: width of generated word. Must satisfy 2**counter_size > word_size.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- bit_count  input  counter_size  requested number of ones; sampled only on accepted start.
- start  input  1  request; level-sampled each edge.
- data  output  word_size  generated word; registered.
- busy  output  1  high while filling.
- done  output  1  high when data holds the final result.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset); it is sampled only on rising clk edges.
- Reset values: state=S_IDLE, data=0, busy=0, done=0, internal remaining counter=0.
- States (one-hot or binary; encoding in package):
  - S_IDLE
  - S_FILL
  - S_DONE
- S_IDLE or S_DONE with start=1 at edge k:
  - Load rem = min(bit_count, word_size) (saturating clamp). Width of rem is counter_size.
  - Clear data to 0, clear done, go to S_FILL, busy=1.
- S_FILL at each edge:
  - If rem != 0: data <= {data[word_size-2:0], 1'b1}, rem <= rem-1, stay in S_FILL.
  - If rem == 0: go to S_DONE, busy=0, done=1.
- Latency: busy is high for exactly Nc+1 cycles (Nc = clamped count). done rises at edge k+Nc+1.
- N=0: one cycle in S_FILL, then done with data=0.
- S_DONE:
  - data and done are held until the next start.
  - start in S_DONE restarts immediately (done drops at the same edge busy rises).
- start while busy: ignored. bit_count changes during fill have no effect.
- start held high continuously: a new run begins on every visit to S_DONE, which is then left after one cycle. done pulses for one cycle per run.
- Reset mid-fill: next edge returns to S_IDLE with all outputs zero. Reset dominates start.
- bit_count > word_size: data saturates to all ones.

Optional Feature:
- Macro: FILL_ONES_OVF_EN.
- When defined, adds output port `overflow` (1 bit, reset 0):
  - Set at the accepted-start edge if bit_count > word_size.
  - Cleared at the next accepted start if not exceeded.
  - Held through S_DONE.
- When undefined, the port is absent and the clamp is silent.

Decomposition:
- Shared package fill_ones_pkg:
  - State typedef/localparams (S_IDLE, S_FILL, S_DONE).
  - Default width constants.
  - Clamp function min_count(bit_count, word_size).
- One natural sub-module: fill_ones_datapath, holding the data shift register and rem down-counter, with load/shift controls driven by the controller FSM in fill_ones_sm.

Test Plan:
- Reset 1 at t=1, released at edge ~t=32; start pulse with bit_count=3 -> busy high 4 cycles; done=1, data=4'b0111, held until the next start.
- bit_count=0, start one cycle -> busy one cycle; done=1, data=4'b0000.
- bit_count=6 (word_size=4) -> busy 5 cycles, data=4'b1111. With FILL_ONES_OVF_EN: overflow=1. A following run with bit_count=2 -> data=4'b0011, overflow=0.
- bit_count=4 start, then start=1 and bit_count=1 pulsed at the second busy cycle -> ignored; result data=4'b1111.
- bit_count=3 start; reset asserted on the second busy cycle -> next edge busy=0, done=0, data=0; a later start with bit_count=2 yields 4'b0011.
- start held high with bit_count=2 -> repeating runs; done is a 1-cycle pulse every 4 cycles; data=4'b0011 each time. Chaining data into the ones-counter returns bit_count=2.

Source files
------------

// File: rtl/fill_ones_pkg.sv
// Shared types and helpers for the serial fill-ones generator.
// Holds the controller state encoding, default widths and the count clamp.
package fill_ones_pkg;

  localparam int DEF_COUNTER_SIZE = 3;
  localparam int DEF_WORD_SIZE    = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A request larger than the word can only ever fill every bit.
  function automatic int min_count(input int bit_count, input int word_size);
    return (bit_count < word_size) ? bit_count : word_size;
  endfunction

endpackage

// File: rtl/fill_ones_sm_if.sv
// Request/result bundle between a requester (master) and the fill-ones block (slave).
// The overflow flag exists only when FILL_ONES_OVF_EN is defined.
interface fill_ones_sm_if
  import fill_ones_pkg::*;
#(
  parameter int counter_size = DEF_COUNTER_SIZE,
  parameter int word_size    = DEF_WORD_SIZE
);

  logic [counter_size-1:0] bit_count;
  logic                    start;
  logic [word_size-1:0]    data;
  logic                    busy;
  logic                    done;
`ifdef FILL_ONES_OVF_EN
  logic                    overflow;

  modport master (output bit_count, output start,
                  input data, input busy, input done, input overflow);
  modport slave  (input bit_count, input start,
                  output data, output busy, output done, output overflow);
`else
  modport master (output bit_count, output start,
                  input data, input busy, input done);
  modport slave  (input bit_count, input start,
                  output data, output busy, output done);
`endif

endinterface

// File: rtl/fill_ones_datapath.sv
// Shift register that collects ones plus the down-counter of ones still to insert.
// load clears the word and captures the clamped count; shift appends one '1' per cycle.
module fill_ones_datapath
  import fill_ones_pkg::*;
#(
  parameter int counter_size = DEF_COUNTER_SIZE,
  parameter int word_size    = DEF_WORD_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    shift,
  input  logic [counter_size-1:0] bit_count,
  output logic [word_size-1:0]    data,
  output logic                    rem_zero
);

  logic [word_size-1:0]    data_q, data_d;
  logic [counter_size-1:0] rem_q, rem_d;

  always_comb begin
    data_d = data_q;
    rem_d  = rem_q;
    if (load) begin
      data_d = '0;
      rem_d  = counter_size'(min_count(int'(bit_count), word_size));
    end else if (shift) begin
      data_d = {data_q[word_size-2:0], 1'b1};
      rem_d  = rem_q - counter_size'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      rem_q  <= '0;
    end else begin
      data_q <= data_d;
      rem_q  <= rem_d;
    end
  end

  assign data     = data_q;
  assign rem_zero = (rem_q == '0);

endmodule

// File: rtl/fill_ones_sm.sv
// Controller for the serial fill-ones generator: start/busy/done handshake around the datapath.
// Optional overflow output is enabled by defining FILL_ONES_OVF_EN.
module fill_ones_sm
  import fill_ones_pkg::*;
#(
  parameter int counter_size = DEF_COUNTER_SIZE,
  parameter int word_size    = DEF_WORD_SIZE
) (
  input  logic           clk,
  input  logic           reset,
  fill_ones_sm_if.slave  bus
);

  state_t state_q, state_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   load, shift, rem_zero;

  // Starts are only honoured outside S_FILL, so a mid-run request is dropped.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = done_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = S_FILL;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_FILL: begin
        if (!rem_zero) begin
          shift = 1'b1;
        end else begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  fill_ones_datapath #(
    .counter_size (counter_size),
    .word_size    (word_size)
  ) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .shift     (shift),
    .bit_count (bus.bit_count),
    .data      (bus.data),
    .rem_zero  (rem_zero)
  );

  assign bus.busy = busy_q;
  assign bus.done = done_q;

`ifdef FILL_ONES_OVF_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q;
    if (load) begin
      overflow_d = (int'(bus.bit_count) > word_size);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign bus.overflow = overflow_q;
`endif

endmodule

// File: tb/tb_fill_ones_sm.sv
// Self-checking bench for fill_ones_sm: vector table, corner-case sequences, random vs. model.
module tb_fill_ones_sm;
  import fill_ones_pkg::*;

  localparam int CS = 3;
  localparam int WS = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fill_ones_sm_if #(.counter_size(CS), .word_size(WS)) bus ();

  fill_ones_sm #(.counter_size(CS), .word_size(WS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int n;
    int exp_data;
    int exp_busy;
    int exp_ovf;
  } vec_t;

  vec_t vecs[8];

  // Behavioural reference: number of ones present and run bookkeeping.
  int m_run, m_fin, m_ones, m_target, m_ovf;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input logic st, input int n, input logic rs);
    if (rs) begin
      m_run = 0; m_fin = 0; m_ones = 0; m_ovf = 0;
    end else if (m_run != 0) begin
      if (m_ones < m_target) m_ones++;
      else begin
        m_run = 0;
        m_fin = 1;
      end
    end else if (st) begin
      m_run    = 1;
      m_fin    = 0;
      m_target = (n < WS) ? n : WS;
      m_ones   = 0;
      m_ovf    = (n > WS) ? 1 : 0;
    end
  endtask

  task automatic run_one(input int n, input int exp_data, input int exp_busy,
                         input int exp_ovf, input string tag);
    int cnt;
    bus.start     = 1'b1;
    bus.bit_count = n[CS-1:0];
    tick();
    bus.start = 1'b0;
    check({tag, "_busy_rise"}, bus.busy, 1);
    check({tag, "_done_clear"}, bus.done, 0);
    check({tag, "_data_clear"}, bus.data, 0);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    check({tag, "_busy_cycles"}, cnt, exp_busy);
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_data"}, bus.data, exp_data);
`ifdef FILL_ONES_OVF_EN
    check({tag, "_ovf"}, bus.overflow, exp_ovf);
`endif
    tick();
    check({tag, "_done_held"}, bus.done, 1);
    check({tag, "_data_held"}, bus.data, exp_data);
  endtask

  initial begin
    int cnt, pulses, last;

    vecs[0] = '{3, 4'b0111, 4, 0};
    vecs[1] = '{0, 4'b0000, 1, 0};
    vecs[2] = '{6, 4'b1111, 5, 1};
    vecs[3] = '{2, 4'b0011, 3, 0};
    vecs[4] = '{4, 4'b1111, 5, 0};
    vecs[5] = '{7, 4'b1111, 5, 1};
    vecs[6] = '{1, 4'b0001, 2, 0};
    vecs[7] = '{5, 4'b1111, 5, 1};

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.bit_count = '0;
    #30;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_data", bus.data, 0);
`ifdef FILL_ONES_OVF_EN
    check("reset_ovf", bus.overflow, 0);
`endif
    #2 reset = 1'b0;
    tick();
    check("idle_busy", bus.busy, 0);
    check("idle_done", bus.done, 0);

    for (int i = 0; i < 8; i++) begin
      run_one(vecs[i].n, vecs[i].exp_data, vecs[i].exp_busy, vecs[i].exp_ovf,
              $sformatf("vec%0d", i));
    end

    // Start and a new count during the second busy cycle must be ignored.
    bus.start     = 1'b1;
    bus.bit_count = 3'd4;
    tick();
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 40) begin
      cnt++;
      if (cnt == 2) begin
        bus.start     = 1'b1;
        bus.bit_count = 3'd1;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    check("ignore_busy_cycles", cnt, 5);
    check("ignore_done", bus.done, 1);
    check("ignore_data", bus.data, 4'b1111);

    // Reset in the middle of a fill.
    bus.start     = 1'b1;
    bus.bit_count = 3'd3;
    tick();
    bus.start = 1'b0;
    tick();
    check("midrst_busy_before", bus.busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_data", bus.data, 0);
    tick();
    check("midrst_idle", bus.busy, 0);
    run_one(2, 4'b0011, 3, 0, "post_reset");

    // Start held high: one done pulse every four cycles.
    bus.start     = 1'b1;
    bus.bit_count = 3'd2;
    pulses = 0;
    last   = -1;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        pulses++;
        check("held_data", bus.data, 4'b0011);
        check("held_roundtrip", $countones(bus.data), 2);
        if (last >= 0) check("held_period", i - last, 4);
        last = i;
      end
    end
    bus.start = 1'b0;
    check("held_pulses", pulses, 6);

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      reset         = (i == 0) || ($urandom_range(0, 49) == 0);
      bus.start     = ($urandom_range(0, 2) == 0);
      bus.bit_count = CS'($urandom_range(0, 7));
      @(posedge clk);
      model_step(bus.start, int'(bus.bit_count), reset);
      #1;
      check("rand_busy", bus.busy, m_run);
      check("rand_done", bus.done, m_fin);
      check("rand_data", bus.data, (1 << m_ones) - 1);
`ifdef FILL_ONES_OVF_EN
      check("rand_ovf", bus.overflow, m_ovf);
`endif
    end
    reset     = 1'b0;
    bus.start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
